fight_referee: RTL

- Downstream match controller for the two player FSMs.
- Consumes each player's 4-bit state word, {place[1:0], health[1:0]}, and produces:
  - the per-tick `control` enable,
  - both lives counters fed back to the players,
  - the between-round player reset,
  - the game-over/winner result.
- Owns the round lifecycle: play, knock-out, respawn, game over.

---
 rtl/fight_referee.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fight_referee.sv
// Match referee for two player FSMs: tick enable, lives, between-round reset and result.
// Optional round timeout enabled by defining REFEREE_ROUND_TIMEOUT_EN.
module fight_referee #(
    parameter int unsigned TICK_DIV    = 25000000,
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned KO_TICKS    = 2,
    parameter int unsigned ROUND_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] p1_state_i,
    input  logic [3:0] p2_state_i,
    input  logic       new_game_i,
    output logic       control_o,
    output logic [1:0] lives1_o,
    output logic [1:0] lives2_o,
    output logic       round_reset_n_o,
    output logic       game_over_o,
    output logic [1:0] winner_o
);
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned KoW   = (KO_TICKS > 1) ? $clog2(KO_TICKS) : 1;

    typedef enum logic [1:0] {StPlay, StKo, StRespawn, StOver} state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [KoW-1:0]   ko_cnt_q, ko_cnt_d;
    logic [1:0]       lives1_q, lives1_d, lives2_q, lives2_d;
    logic             control_q, control_d;
    logic             round_reset_n_q, round_reset_n_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       winner_q, winner_d;

    logic tick_wrap, ko1, ko2, ko_any, ko_done;
    logic timeout, lose1, lose2;
    logic unused_place;

    assign tick_wrap = (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign ko1       = (p1_state_i[1:0] == 2'b00);
    assign ko2       = (p2_state_i[1:0] == 2'b00);
    assign ko_any    = ko1 || ko2;
    assign ko_done   = tick_wrap && (ko_cnt_q == KoW'(KO_TICKS - 1));
    assign unused_place = ^{p1_state_i[3:2], p2_state_i[3:2]};

`ifdef REFEREE_ROUND_TIMEOUT_EN
    localparam int unsigned RoundW = $clog2(ROUND_TICKS + 1);

    logic [RoundW-1:0] round_cnt_q, round_cnt_d;

    // Counts visible control pulses; held at zero outside PLAY.
    always_comb begin
        round_cnt_d = round_cnt_q;
        if (state_q != StPlay) begin
            round_cnt_d = '0;
        end else if (control_q) begin
            round_cnt_d = round_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_cnt_q <= '0;
        end else begin
            round_cnt_q <= round_cnt_d;
        end
    end

    assign timeout = (state_q == StPlay) && control_q &&
                     (round_cnt_q == RoundW'(ROUND_TICKS - 1));
    assign lose1   = timeout && (p1_state_i[1:0] < p2_state_i[1:0]);
    assign lose2   = timeout && (p2_state_i[1:0] < p1_state_i[1:0]);
`else
    logic unused_round_ticks;
    assign unused_round_ticks = (ROUND_TICKS == 0);
    assign timeout = 1'b0;
    assign lose1   = 1'b0;
    assign lose2   = 1'b0;
`endif

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v != 2'd0) ? v - 2'd1 : 2'd0;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StPlay;
            tick_cnt_q      <= '0;
            ko_cnt_q        <= '0;
            lives1_q        <= 2'(START_LIVES);
            lives2_q        <= 2'(START_LIVES);
            control_q       <= 1'b0;
            round_reset_n_q <= 1'b1;
            game_over_q     <= 1'b0;
            winner_q        <= 2'b00;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            ko_cnt_q        <= ko_cnt_d;
            lives1_q        <= lives1_d;
            lives2_q        <= lives2_d;
            control_q       <= control_d;
            round_reset_n_q <= round_reset_n_d;
            game_over_q     <= game_over_d;
            winner_q        <= winner_d;
        end
    end

    // A KO in the same cycle as a timeout wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPlay: begin
                if (ko_any) begin
                    state_d = StKo;
                end else if (timeout) begin
                    state_d = (lose1 || lose2) ? StKo : StRespawn;
                end
            end
            StKo: begin
                if (ko_done) begin
                    state_d = (lives1_q == 2'd0 || lives2_q == 2'd0) ? StOver : StRespawn;
                end
            end
            StRespawn: state_d = StPlay;
            StOver: begin
                if (new_game_i) begin
                    state_d = StRespawn;
                end
            end
            default: state_d = StPlay;
        endcase
    end

    // Next values for counters, lives and the registered outputs.
    always_comb begin
        tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
        ko_cnt_d   = ko_cnt_q;
        lives1_d   = lives1_q;
        lives2_d   = lives2_q;
        unique case (state_q)
            StPlay: begin
                if (state_d != StPlay) begin
                    tick_cnt_d = '0;
                    ko_cnt_d   = '0;
                end
                if (ko_any) begin
                    if (ko1) lives1_d = sat_dec(lives1_q);
                    if (ko2) lives2_d = sat_dec(lives2_q);
                end else begin
                    if (lose1) lives1_d = sat_dec(lives1_q);
                    if (lose2) lives2_d = sat_dec(lives2_q);
                end
            end
            StKo: begin
                if (ko_done) begin
                    ko_cnt_d = '0;
                end else if (tick_wrap) begin
                    ko_cnt_d = ko_cnt_q + 1'b1;
                end
            end
            StRespawn: begin
                tick_cnt_d = '0;
                ko_cnt_d   = '0;
            end
            StOver: begin
                tick_cnt_d = '0;
                if (new_game_i) begin
                    lives1_d = 2'(START_LIVES);
                    lives2_d = 2'(START_LIVES);
                end
            end
            default: ;
        endcase

        control_d       = (state_q == StPlay) && (state_d == StPlay) && tick_wrap;
        round_reset_n_d = (state_d != StRespawn);
        game_over_d     = (state_d == StOver);
        winner_d        = game_over_d ? {lives1_d == 2'd0, lives2_d == 2'd0} : 2'b00;
    end

    assign control_o       = control_q;
    assign lives1_o        = lives1_q;
    assign lives2_o        = lives2_q;
    assign round_reset_n_o = round_reset_n_q;
    assign game_over_o     = game_over_q;
    assign winner_o        = winner_q;
endmodule
